// File: rtl/gemm_pkg.sv
// Shared types for the tile command scheduler: command bundle, FSM encoding, index-width helper.
// Pure declarations; no latency, no flow control.
package gemm_pkg;

  typedef struct packed {
    logic [15:0] left_addr;
    logic [15:0] right_addr;
    logic [7:0]  dim_b;
    logic [7:0]  dim_c;
    logic [7:0]  dim_v;
    logic        left_man_4b;
    logic        right_man_4b;
    logic        loop_over_left;
  } tile_cmd_t;

  // Encoding 2 is reserved so the debug state field stays stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_ISSUE         = 2'd1,
    ST_TIMEOUT_FLUSH = 2'd3
  } sched_state_t;

  function automatic int ce_idx_w(input int num_ce);
    return (num_ce > 1) ? $clog2(num_ce) : 1;
  endfunction

endpackage

// File: rtl/tile_sched_rr_arb.sv
// Rotating-priority arbiter: first requester strictly after ptr wins, wrapping at N.
// Combinational, zero latency; no backpressure (grant is advisory until the caller commits).
module tile_sched_rr_arb
  import gemm_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ce_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    // Offset 1..N visits every engine once, ptr itself last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tile_cmd_scheduler.sv
// Issues TILE commands round-robin to idle, non-afull engines; drops zero-dim commands. Optional TILE_SCHED_WATCHDOG_EN.
// Latency: accept at T, one-hot tile_en at T+1, busy visible at T+2; one issue per 2 cycles.
// Backpressure: o_cmd_ready low outside ST_IDLE or when no engine is eligible (zero-dim commands always taken in ST_IDLE).
module tile_cmd_scheduler
  import gemm_pkg::*;
#(
  parameter int NUM_CE         = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [15:0]       i_cmd_left_addr,
  input  logic [15:0]       i_cmd_right_addr,
  input  logic [7:0]        i_cmd_dim_b,
  input  logic [7:0]        i_cmd_dim_c,
  input  logic [7:0]        i_cmd_dim_v,
  input  logic              i_cmd_left_man_4b,
  input  logic              i_cmd_right_man_4b,
  input  logic              i_cmd_loop_over_left,
  output logic [NUM_CE-1:0] o_ce_tile_en,
  output logic [15:0]       o_ce_left_addr,
  output logic [15:0]       o_ce_right_addr,
  output logic [7:0]        o_ce_dim_b,
  output logic [7:0]        o_ce_dim_c,
  output logic [7:0]        o_ce_dim_v,
  output logic              o_ce_left_man_4b,
  output logic              o_ce_right_man_4b,
  output logic              o_ce_loop_over_left,
  input  logic [NUM_CE-1:0] i_ce_tile_done,
  input  logic [NUM_CE-1:0] i_ce_result_afull,
  output logic [NUM_CE-1:0] o_ce_busy,
  output logic              o_all_idle,
  output logic [CNT_W-1:0]  o_issue_count,
  output logic [CNT_W-1:0]  o_done_count,
  output logic [CNT_W-1:0]  o_drop_count,
  output logic              o_err_zero_dim,
  output logic              o_err_spurious_done,
  output logic [1:0]        o_state
`ifdef TILE_SCHED_WATCHDOG_EN
  ,
  output logic [NUM_CE-1:0] o_err_timeout
`endif
);

  localparam int IW = ce_idx_w(NUM_CE);

  if (NUM_CE < 2 || NUM_CE > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tile_cmd_scheduler: NUM_CE must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  sched_state_t      state_q, state_d;
  logic [NUM_CE-1:0] busy_q, busy_d;
  logic [NUM_CE-1:0] tile_en_q, tile_en_d;
  tile_cmd_t         bus_q, bus_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              err_zero_q, err_zero_d;
  logic              err_spur_q, err_spur_d;

  tile_cmd_t         cmd_in;
  logic [NUM_CE-1:0] eligible, arb_gnt, done_ok, done_bad;
  logic [IW-1:0]     arb_idx;
  logic              arb_any, zero_dim, cmd_fire;
  logic [CNT_W-1:0]  done_inc;

  always_comb begin
    cmd_in.left_addr      = i_cmd_left_addr;
    cmd_in.right_addr     = i_cmd_right_addr;
    cmd_in.dim_b          = i_cmd_dim_b;
    cmd_in.dim_c          = i_cmd_dim_c;
    cmd_in.dim_v          = i_cmd_dim_v;
    cmd_in.left_man_4b    = i_cmd_left_man_4b;
    cmd_in.right_man_4b   = i_cmd_right_man_4b;
    cmd_in.loop_over_left = i_cmd_loop_over_left;
  end

  assign eligible = ~busy_q & ~i_ce_result_afull;
  assign zero_dim = (i_cmd_dim_b == 8'd0) || (i_cmd_dim_c == 8'd0) || (i_cmd_dim_v == 8'd0);
  assign o_cmd_ready = (state_q == ST_IDLE) && (arb_any || zero_dim);
  assign cmd_fire = i_cmd_valid && o_cmd_ready;
  assign done_ok  = i_ce_tile_done & busy_q;
  assign done_bad = i_ce_tile_done & ~busy_q;

  tile_sched_rr_arb #(.N(NUM_CE), .IW(IW)) u_arb (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      done_inc = done_inc + CNT_W'(done_ok[i]);
    end
  end

`ifdef TILE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]   wd_q [NUM_CE];
  logic [WD_W-1:0]   wd_d [NUM_CE];
  logic [NUM_CE-1:0] timeout_hit;
  logic [NUM_CE-1:0] err_to_q, err_to_d;

  // Hit on the TIMEOUT_CYCLES-th busy cycle so busy clears after exactly that many.
  always_comb begin
    for (int i = 0; i < NUM_CE; i++) begin
      timeout_hit[i] = busy_q[i] && !done_ok[i] && (wd_q[i] == WD_W'(TIMEOUT_CYCLES - 1));
      wd_d[i] = (busy_q[i] && !done_ok[i] && !timeout_hit[i]) ? wd_q[i] + 1'b1 : '0;
    end
    err_to_d = err_to_q | timeout_hit;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_to_q <= '0;
      for (int i = 0; i < NUM_CE; i++) wd_q[i] <= '0;
    end else begin
      err_to_q <= err_to_d;
      for (int i = 0; i < NUM_CE; i++) wd_q[i] <= wd_d[i];
    end
  end

  assign o_err_timeout = err_to_q;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = (busy_q & ~done_ok) | tile_en_q;
    tile_en_d   = '0;
    bus_d       = bus_q;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q + done_inc;
    drop_cnt_d  = drop_cnt_q;
    err_zero_d  = err_zero_q;
    err_spur_d  = err_spur_q | (|done_bad);
`ifdef TILE_SCHED_WATCHDOG_EN
    busy_d = busy_d & ~timeout_hit;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (zero_dim) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
            err_zero_d = 1'b1;
          end else begin
            bus_d     = cmd_in;
            tile_en_d = arb_gnt;
            ptr_d     = arb_idx;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        state_d     = ST_IDLE;
`ifdef TILE_SCHED_WATCHDOG_EN
        if (|timeout_hit) state_d = ST_TIMEOUT_FLUSH;
`endif
      end
      ST_TIMEOUT_FLUSH: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= '0;
      tile_en_q   <= '0;
      bus_q       <= '0;
      ptr_q       <= IW'(NUM_CE - 1);
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      err_zero_q  <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      tile_en_q   <= tile_en_d;
      bus_q       <= bus_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_zero_q  <= err_zero_d;
      err_spur_q  <= err_spur_d;
    end
  end

  assign o_ce_tile_en        = tile_en_q;
  assign o_ce_left_addr      = bus_q.left_addr;
  assign o_ce_right_addr     = bus_q.right_addr;
  assign o_ce_dim_b          = bus_q.dim_b;
  assign o_ce_dim_c          = bus_q.dim_c;
  assign o_ce_dim_v          = bus_q.dim_v;
  assign o_ce_left_man_4b    = bus_q.left_man_4b;
  assign o_ce_right_man_4b   = bus_q.right_man_4b;
  assign o_ce_loop_over_left = bus_q.loop_over_left;
  assign o_ce_busy           = busy_q;
  assign o_all_idle          = (state_q == ST_IDLE) && (busy_q == '0);
  assign o_issue_count       = issue_cnt_q;
  assign o_done_count        = done_cnt_q;
  assign o_drop_count        = drop_cnt_q;
  assign o_err_zero_dim      = err_zero_q;
  assign o_err_spurious_done = err_spur_q;
  assign o_state             = state_q;

endmodule

// File: tb/tb_tile_cmd_scheduler.sv
// Directed bench for tile_cmd_scheduler (NUM_CE=4): issue timing, round-robin, afull skip, drops, dones, async reset.
module tb_tile_cmd_scheduler;

  localparam int N = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [15:0]   i_cmd_left_addr = '0;
  logic [15:0]   i_cmd_right_addr = '0;
  logic [7:0]    i_cmd_dim_b = 8'd1;
  logic [7:0]    i_cmd_dim_c = 8'd1;
  logic [7:0]    i_cmd_dim_v = 8'd1;
  logic          i_cmd_left_man_4b = 1'b0;
  logic          i_cmd_right_man_4b = 1'b0;
  logic          i_cmd_loop_over_left = 1'b0;
  logic [N-1:0]  o_ce_tile_en;
  logic [15:0]   o_ce_left_addr, o_ce_right_addr;
  logic [7:0]    o_ce_dim_b, o_ce_dim_c, o_ce_dim_v;
  logic          o_ce_left_man_4b, o_ce_right_man_4b, o_ce_loop_over_left;
  logic [N-1:0]  i_ce_tile_done = '0;
  logic [N-1:0]  i_ce_result_afull = '0;
  logic [N-1:0]  o_ce_busy;
  logic          o_all_idle;
  logic [15:0]   o_issue_count, o_done_count, o_drop_count;
  logic          o_err_zero_dim, o_err_spurious_done;
  logic [1:0]    o_state;
`ifdef TILE_SCHED_WATCHDOG_EN
  logic [N-1:0]  o_err_timeout;
`endif

  tile_cmd_scheduler #(.NUM_CE(N), .CNT_W(16)) dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_cmd_valid          (i_cmd_valid),
    .o_cmd_ready          (o_cmd_ready),
    .i_cmd_left_addr      (i_cmd_left_addr),
    .i_cmd_right_addr     (i_cmd_right_addr),
    .i_cmd_dim_b          (i_cmd_dim_b),
    .i_cmd_dim_c          (i_cmd_dim_c),
    .i_cmd_dim_v          (i_cmd_dim_v),
    .i_cmd_left_man_4b    (i_cmd_left_man_4b),
    .i_cmd_right_man_4b   (i_cmd_right_man_4b),
    .i_cmd_loop_over_left (i_cmd_loop_over_left),
    .o_ce_tile_en         (o_ce_tile_en),
    .o_ce_left_addr       (o_ce_left_addr),
    .o_ce_right_addr      (o_ce_right_addr),
    .o_ce_dim_b           (o_ce_dim_b),
    .o_ce_dim_c           (o_ce_dim_c),
    .o_ce_dim_v           (o_ce_dim_v),
    .o_ce_left_man_4b     (o_ce_left_man_4b),
    .o_ce_right_man_4b    (o_ce_right_man_4b),
    .o_ce_loop_over_left  (o_ce_loop_over_left),
    .i_ce_tile_done       (i_ce_tile_done),
    .i_ce_result_afull    (i_ce_result_afull),
    .o_ce_busy            (o_ce_busy),
    .o_all_idle           (o_all_idle),
    .o_issue_count        (o_issue_count),
    .o_done_count         (o_done_count),
    .o_drop_count         (o_drop_count),
    .o_err_zero_dim       (o_err_zero_dim),
    .o_err_spurious_done  (o_err_spurious_done),
    .o_state              (o_state)
`ifdef TILE_SCHED_WATCHDOG_EN
    ,
    .o_err_timeout        (o_err_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cmd(input logic [7:0] b, input logic [7:0] c, input logic [7:0] v,
                         input logic [15:0] la, input logic [15:0] ra);
    i_cmd_dim_b      = b;
    i_cmd_dim_c      = c;
    i_cmd_dim_v      = v;
    i_cmd_left_addr  = la;
    i_cmd_right_addr = ra;
  endtask

  task automatic pulse_reset();
    i_cmd_valid       = 1'b0;
    i_ce_tile_done    = '0;
    i_ce_result_afull = '0;
    i_reset           = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  // Accept one command, expect the pulse on engine exp_ce, return to ST_IDLE.
  task automatic issue_one(input string tag, input int exp_ce);
    i_cmd_valid = 1'b1;
    #1 check({tag, "_ready"}, 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
    check({tag, "_tile_en"}, 32'(o_ce_tile_en), 32'(1 << exp_ce));
    tick();
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_busy", 32'(o_ce_busy), 32'd0);
    check("rst_tile_en", 32'(o_ce_tile_en), 32'd0);
    check("rst_issue", 32'(o_issue_count), 32'd0);
    check("rst_done", 32'(o_done_count), 32'd0);
    check("rst_drop", 32'(o_drop_count), 32'd0);
    check("rst_errs", 32'({o_err_zero_dim, o_err_spurious_done}), 32'd0);
    check("rst_left", 32'(o_ce_left_addr), 32'd0);
    check("rst_all_idle", 32'(o_all_idle), 32'd1);
    i_reset = 1'b0;

    // Single command
    set_cmd(8'd2, 8'd2, 8'd4, 16'h0010, 16'h0200);
    i_cmd_left_man_4b    = 1'b1;
    i_cmd_right_man_4b   = 1'b0;
    i_cmd_loop_over_left = 1'b1;
    i_cmd_valid = 1'b1;
    #1 check("t1_ready", 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
    check("t1_tile_en", 32'(o_ce_tile_en), 32'h1);
    check("t1_state", 32'(o_state), 32'd1);
    check("t1_left", 32'(o_ce_left_addr), 32'h0010);
    check("t1_right", 32'(o_ce_right_addr), 32'h0200);
    check("t1_dims", 32'({o_ce_dim_b, o_ce_dim_c, o_ce_dim_v}), 32'h020204);
    check("t1_flags", 32'({o_ce_left_man_4b, o_ce_right_man_4b, o_ce_loop_over_left}), 32'b101);
    check("t1_busy_early", 32'(o_ce_busy), 32'd0);
    tick();
    check("t1_tile_en_off", 32'(o_ce_tile_en), 32'd0);
    check("t1_busy", 32'(o_ce_busy), 32'h1);
    check("t1_issue", 32'(o_issue_count), 32'd1);
    check("t1_bus_hold", 32'(o_ce_left_addr), 32'h0010);
    i_ce_tile_done = 4'b0001;
    tick();
    i_ce_tile_done = '0;
    check("t1_busy_clr", 32'(o_ce_busy), 32'd0);
    check("t1_done", 32'(o_done_count), 32'd1);

    // Back-to-back: 0,1,2,3 then stall until engine 2 completes
    pulse_reset();
    set_cmd(8'd1, 8'd1, 8'd1, 16'h0100, 16'h0300);
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b2b_tile_en", 32'(o_ce_tile_en), 32'(1 << k));
      tick();
    end
    check("b2b_busy_full", 32'(o_ce_busy), 32'hF);
    check("b2b_ready_low", 32'(o_cmd_ready), 32'd0);
    tick();
    check("b2b_stall_en", 32'(o_ce_tile_en), 32'd0);
    check("b2b_issue4", 32'(o_issue_count), 32'd4);
    i_ce_tile_done = 4'b0100;
    tick();
    i_ce_tile_done = '0;
    check("b2b_busy_1011", 32'(o_ce_busy), 32'hB);
    check("b2b_ready_back", 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
    check("b2b_5th_ce2", 32'(o_ce_tile_en), 32'h4);
    tick();
    check("b2b_issue5", 32'(o_issue_count), 32'd5);
    check("b2b_done1", 32'(o_done_count), 32'd1);

    // Zero-dim command while every engine is busy
    set_cmd(8'd3, 8'd3, 8'd0, 16'h0AAA, 16'h0BBB);
    i_cmd_valid = 1'b1;
    #1 check("zd_ready", 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
    check("zd_drop", 32'(o_drop_count), 32'd1);
    check("zd_err", 32'(o_err_zero_dim), 32'd1);
    check("zd_state", 32'(o_state), 32'd0);
    check("zd_no_en", 32'(o_ce_tile_en), 32'd0);
    check("zd_bus_kept", 32'(o_ce_left_addr), 32'h0100);
    tick();
    check("zd_issue", 32'(o_issue_count), 32'd5);

    // Dones on 0 and 3 during the issue to engine 1, then a spurious done
    i_ce_tile_done = 4'b0110;
    tick();
    i_ce_tile_done = '0;
    check("sd_busy_1001", 32'(o_ce_busy), 32'h9);
    check("sd_done3", 32'(o_done_count), 32'd3);
    set_cmd(8'd4, 8'd4, 8'd4, 16'h0040, 16'h0050);
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_ce_tile_done = 4'b1001;
    check("sd_tile_en", 32'(o_ce_tile_en), 32'h2);
    tick();
    i_ce_tile_done = '0;
    check("sd_busy_0010", 32'(o_ce_busy), 32'h2);
    check("sd_done5", 32'(o_done_count), 32'd5);
    check("sd_issue6", 32'(o_issue_count), 32'd6);
    check("sd_no_spur", 32'(o_err_spurious_done), 32'd0);
    i_ce_tile_done = 4'b0100;
    tick();
    i_ce_tile_done = '0;
    check("sp_err", 32'(o_err_spurious_done), 32'd1);
    check("sp_done", 32'(o_done_count), 32'd5);
    check("sp_busy", 32'(o_ce_busy), 32'h2);

    // Afull skip with pointer at 0
    pulse_reset();
    check("af_rst_spur", 32'(o_err_spurious_done), 32'd0);
    issue_one("af_ce0", 0);
    i_ce_tile_done = 4'b0001;
    tick();
    i_ce_tile_done = '0;
    i_ce_result_afull = 4'b0010;
    issue_one("af_skip1", 2);
    issue_one("af_ce3", 3);
    issue_one("af_ce0b", 0);
    check("af_busy_1101", 32'(o_ce_busy), 32'hD);
    check("af_ready_low", 32'(o_cmd_ready), 32'd0);
    i_ce_result_afull = '0;
    #1 check("af_ready_clr", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_ce_result_afull = 4'b0010;
    check("af_late_afull", 32'(o_ce_tile_en), 32'h2);
    tick();
    check("af_busy_full", 32'(o_ce_busy), 32'hF);
    check("af_issue5", 32'(o_issue_count), 32'd5);
    i_ce_result_afull = '0;

    // Reset asserted during ST_ISSUE
    i_ce_tile_done = 4'b0001;
    tick();
    i_ce_tile_done = '0;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check("ri_state_issue", 32'(o_state), 32'd1);
    check("ri_tile_en", 32'(o_ce_tile_en), 32'h1);
    #1 i_reset = 1'b1;
    #1;
    check("ri_async_en", 32'(o_ce_tile_en), 32'd0);
    check("ri_async_state", 32'(o_state), 32'd0);
    check("ri_async_busy", 32'(o_ce_busy), 32'd0);
    check("ri_async_issue", 32'(o_issue_count), 32'd0);
    check("ri_async_left", 32'(o_ce_left_addr), 32'd0);
    #1 i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ri_no_pulse", 32'(o_ce_tile_en), 32'd0);
    end
    check("ri_issue0", 32'(o_issue_count), 32'd0);
    check("ri_all_idle", 32'(o_all_idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_cmd_scheduler.md
Name: tile_cmd_scheduler

Overview:
- Accepts TILE commands from the master command path and issues each one to an idle compute engine in a pool of NUM_CE compute_engine_modular instances.
- Selects the target engine by round-robin.
- Tracks the busy state of each engine from its tile_done pulse.
- Withholds an engine whose result FIFO is almost full.
- Drops degenerate (zero-dimension) commands and reports status and counters.

Parameters:
- NUM_CE, 4, number of compute engines in the pool (2..16).
- CNT_W, 16, width of the issue, done and drop counters.
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles. Used only with the optional feature.

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready
- i_cmd_left_addr  in  16  left matrix start address
- i_cmd_right_addr  in  16  right matrix start address
- i_cmd_dim_b  in  8  left UGD length (B)
- i_cmd_dim_c  in  8  right UGD length (C)
- i_cmd_dim_v  in  8  vector length (V)
- i_cmd_left_man_4b, i_cmd_right_man_4b, i_cmd_loop_over_left  in  1 each  mode flags
- o_ce_tile_en  out  NUM_CE  one-hot, single-cycle issue pulse
- o_ce_left_addr, o_ce_right_addr  out  16  shared parameter bus
- o_ce_dim_b, o_ce_dim_c, o_ce_dim_v  out  8  shared parameter bus
- o_ce_left_man_4b, o_ce_right_man_4b, o_ce_loop_over_left  out  1  shared parameter bus
- i_ce_tile_done  in  NUM_CE  per-engine done pulse
- i_ce_result_afull  in  NUM_CE  per-engine result FIFO almost full
- o_ce_busy  out  NUM_CE  busy vector
- o_all_idle  out  1  state is ST_IDLE and no engine is busy
- o_issue_count, o_done_count, o_drop_count  out  CNT_W  wrapping counters
- o_err_zero_dim  out  1  sticky
- o_err_spurious_done  out  1  sticky
- o_state  out  2  debug state

Behaviour:
- Reset (async on i_reset high):
  - state ST_IDLE
  - busy, tile_en, parameter bus, counters and sticky errors all cleared
  - round-robin pointer set to NUM_CE-1, so engine 0 wins first
  - a reset mid-operation abandons any pending issue; no tile_en pulse is emitted afterwards
- States:
  - ST_IDLE (0) to ST_ISSUE (1) on accepting a valid, non-zero command.
  - ST_ISSUE lasts exactly one cycle, then returns to ST_IDLE. Throughput is one issue per 2 cycles.
  - Encoding 2 is reserved; 3 is ST_TIMEOUT_FLUSH, used only with the optional feature.
- Eligibility: eligible[i] = !busy[i] && !i_ce_result_afull[i].
- o_cmd_ready (combinational from registers plus afull) = ST_IDLE && (any eligible || incoming command has a zero dimension).
- Zero-dimension command (B, C or V equal to 0) while in ST_IDLE:
  - accepted; no engine is needed
  - not issued
  - o_drop_count increments and o_err_zero_dim is set
  - state stays ST_IDLE
- Accept cycle (T):
  - command fields are registered onto the shared parameter bus
  - grant is the first eligible index found searching upward from pointer+1, wrapping at NUM_CE
  - grant index is registered and the pointer is updated to the grant
- Cycle T+1 (ST_ISSUE):
  - o_ce_tile_en[grant] is high for exactly one cycle
  - busy[grant] is set (visible at T+2)
  - o_issue_count increments
- Parameter bus is held stable from T+1 until the next accept. Engines sample it on tile_en.
- Done handling:
  - i_ce_tile_done[i] with busy[i] set clears busy[i] on the next edge and increments o_done_count.
  - Done with busy[i] clear is ignored for busy/counters and sets o_err_spurious_done.
  - Multiple dones in the same cycle are all processed; o_done_count adds the popcount.
  - Done on engine j in the same cycle as an issue to engine k (j≠k) processes both.
  - A done cannot coincide with an issue to the same engine, because a busy engine is never eligible.
- Afull asserted after a grant does not cancel the issue.
- Counters wrap modulo 2^CNT_W. Sticky errors clear only on reset.

Optional Feature:
- Macro: TILE_SCHED_WATCHDOG_EN.
- With the macro defined:
  - per-engine cycle counter runs while busy and clears on done
  - reaching TIMEOUT_CYCLES forces busy[i] to 0 and sets bit i of an extra sticky output o_err_timeout[NUM_CE-1:0]
  - the forced clear does not increment o_done_count
  - if the timeout hits during ST_ISSUE, state passes through ST_TIMEOUT_FLUSH for one cycle before ST_IDLE
- Without the macro: no counters and no o_err_timeout port; encoding 3 is unused.

Decomposition:
- gemm_pkg holds:
  - tile_cmd_t packed struct (addresses, dimensions, flags)
  - sched_state_t enum (ST_IDLE, ST_ISSUE, ST_TIMEOUT_FLUSH)
  - function ce_idx_w(NUM_CE) = $clog2(NUM_CE)
- One sub-module: tile_sched_rr_arb.
  - Combinational rotating-priority arbiter.
  - Inputs: request vector and pointer. Outputs: one-hot grant, encoded index, any_grant.

Test Plan:
- Single command (B=2, C=2, V=4, left_addr=0x0010): accepted at T; o_ce_tile_en=4'b0001 at T+1 only; parameter bus matches; o_ce_busy=4'b0001 at T+2; done pulse clears busy next cycle; issue and done counts both 1.
- Five back-to-back commands with no dones: engines 0,1,2,3 granted in order on alternate cycles; 5th command sees o_cmd_ready=0 until i_ce_tile_done[2] pulses, then is granted to engine 2.
- i_ce_result_afull=4'b0010 with all engines idle and pointer=0: grant skips engine 1 and goes to engine 2; clearing afull later makes engine 1 eligible again.
- Command with V=0 while all engines are busy: accepted immediately, no tile_en, o_drop_count=1, o_err_zero_dim=1.
- Simultaneous dones on engines 0 and 3 while issuing to engine 1: o_done_count +2, issue completes, busy=4'b0010; done on idle engine 2 sets o_err_spurious_done with counts unchanged.
- i_reset asserted in ST_ISSUE: all outputs return to reset values asynchronously; no tile_en pulse after deassertion; with TILE_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=100, an engine with no done clears after 100 cycles and o_err_timeout[0]=1.
